// File: rtl/alu_ctrl_gen.sv
// -----------------------------------------------------------------------------
// alu_ctrl_gen
// ID-stage ALU control and immediate generator for an RV32I pipeline. Decodes
// the ID instruction into an ALU opcode, operand selects and a sign-extended
// immediate, and registers them into the ID/EX slot.
//
// Ports
//   clk                  : clock, rising edge
//   rst_n                : asynchronous active-low reset
//   instr_ID_i           : instruction word in ID
//   valid_ID_i           : instr_ID_i is live
//   stall_i              : hold the ID/EX slot
//   flush_i              : load a bubble into the ID/EX slot (beats stall)
//   alu_ctrl_ID_EX_o     : ALU opcode (0 add,1 sub,2 sll,3 slt,4 sltu,
//                          5 xor,6 srl,7 sra,8 or,9 and)
//   alu_src_imm_ID_EX_o  : operand 2 is the immediate
//   alu_src_pc_ID_EX_o   : operand 1 is the PC
//   alu_zero_rs1_ID_EX_o : operand 1 forced to zero (LUI)
//   imm_ID_EX_o          : sign-extended immediate
//   valid_ID_EX_o        : ID/EX slot is live
//   illegal_ID_EX_o      : illegal encoding flag (only with the macro below)
//
// Build option
//   ILLEGAL_INSN_DETECT_EN : when defined, illegal encodings enter the slot
//   as valid instructions flagged on illegal_ID_EX_o; when undefined, they
//   are squashed to a bubble and the port does not exist.
// -----------------------------------------------------------------------------
module alu_ctrl_gen #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_ID_i,
    input  logic                  valid_ID_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic [3:0]            alu_ctrl_ID_EX_o,
    output logic                  alu_src_imm_ID_EX_o,
    output logic                  alu_src_pc_ID_EX_o,
    output logic                  alu_zero_rs1_ID_EX_o,
    output logic [DATA_WIDTH-1:0] imm_ID_EX_o,
    output logic                  valid_ID_EX_o
`ifdef ILLEGAL_INSN_DETECT_EN
    ,
    output logic                  illegal_ID_EX_o
`endif
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Plain funct3 -> opcode map; the funct7[5] variants are handled by callers.
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;

    assign opcode = instr_ID_i[6:0];
    assign funct3 = instr_ID_i[14:12];
    assign funct7 = instr_ID_i[31:25];

    assign imm_i     = {{20{instr_ID_i[31]}}, instr_ID_i[31:20]};
    assign imm_s     = {{20{instr_ID_i[31]}}, instr_ID_i[31:25], instr_ID_i[11:7]};
    assign imm_b     = {{19{instr_ID_i[31]}}, instr_ID_i[31], instr_ID_i[7],
                        instr_ID_i[30:25], instr_ID_i[11:8], 1'b0};
    assign imm_u     = {instr_ID_i[31:12], 12'b0};
    assign imm_j     = {{11{instr_ID_i[31]}}, instr_ID_i[31], instr_ID_i[19:12],
                        instr_ID_i[20], instr_ID_i[30:21], 1'b0};
    assign imm_shamt = {27'b0, instr_ID_i[24:20]};

    logic [3:0]            dec_ctrl;
    logic                  dec_imm;
    logic                  dec_pc;
    logic                  dec_zero;
    logic [31:0]           dec_imm32;
    logic                  dec_legal;
    logic [DATA_WIDTH-1:0] dec_imm_ext;

    always_comb begin
        dec_ctrl  = ALU_ADD;
        dec_imm   = 1'b0;
        dec_pc    = 1'b0;
        dec_zero  = 1'b0;
        dec_imm32 = 32'b0;
        dec_legal = 1'b1;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_ZERO) begin
                    dec_ctrl = base_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_ctrl = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_ctrl = ALU_SRA;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OPC_OPIMM: begin
                dec_imm = 1'b1;
                if (funct3 == 3'b001) begin
                    dec_ctrl  = ALU_SLL;
                    dec_imm32 = imm_shamt;
                    dec_legal = (funct7 == F7_ZERO);
                end else if (funct3 == 3'b101) begin
                    dec_ctrl  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    dec_imm32 = imm_shamt;
                    dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                end else begin
                    dec_ctrl  = base_op(funct3);
                    dec_imm32 = imm_i;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                dec_imm   = 1'b1;
                dec_imm32 = imm_i;
            end
            OPC_STORE: begin
                dec_imm   = 1'b1;
                dec_imm32 = imm_s;
            end
            OPC_JAL: begin
                dec_imm   = 1'b1;
                dec_pc    = 1'b1;
                dec_imm32 = imm_j;
            end
            OPC_AUIPC: begin
                dec_imm   = 1'b1;
                dec_pc    = 1'b1;
                dec_imm32 = imm_u;
            end
            OPC_LUI: begin
                dec_imm   = 1'b1;
                dec_zero  = 1'b1;
                dec_imm32 = imm_u;
            end
            OPC_BRANCH: begin
                dec_imm32 = imm_b;
                case (funct3)
                    3'b100, 3'b101: dec_ctrl = ALU_SLT;
                    3'b110, 3'b111: dec_ctrl = ALU_SLTU;
                    default:        dec_ctrl = ALU_SUB;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_imm_ext = DATA_WIDTH'($signed(dec_imm32));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl_ID_EX_o     <= '0;
            alu_src_imm_ID_EX_o  <= 1'b0;
            alu_src_pc_ID_EX_o   <= 1'b0;
            alu_zero_rs1_ID_EX_o <= 1'b0;
            imm_ID_EX_o          <= '0;
            valid_ID_EX_o        <= 1'b0;
`ifdef ILLEGAL_INSN_DETECT_EN
            illegal_ID_EX_o      <= 1'b0;
`endif
        end else if (flush_i || (!stall_i && !valid_ID_i)) begin
            alu_ctrl_ID_EX_o     <= '0;
            alu_src_imm_ID_EX_o  <= 1'b0;
            alu_src_pc_ID_EX_o   <= 1'b0;
            alu_zero_rs1_ID_EX_o <= 1'b0;
            imm_ID_EX_o          <= '0;
            valid_ID_EX_o        <= 1'b0;
`ifdef ILLEGAL_INSN_DETECT_EN
            illegal_ID_EX_o      <= 1'b0;
`endif
        end else if (!stall_i) begin
            if (dec_legal) begin
                alu_ctrl_ID_EX_o     <= dec_ctrl;
                alu_src_imm_ID_EX_o  <= dec_imm;
                alu_src_pc_ID_EX_o   <= dec_pc;
                alu_zero_rs1_ID_EX_o <= dec_zero;
                imm_ID_EX_o          <= dec_imm_ext;
                valid_ID_EX_o        <= 1'b1;
`ifdef ILLEGAL_INSN_DETECT_EN
                illegal_ID_EX_o      <= 1'b0;
`endif
            end else begin
                // Illegal encodings carry no operation: everything but the
                // slot valid (and flag, when detection is built in) is zero.
                alu_ctrl_ID_EX_o     <= '0;
                alu_src_imm_ID_EX_o  <= 1'b0;
                alu_src_pc_ID_EX_o   <= 1'b0;
                alu_zero_rs1_ID_EX_o <= 1'b0;
                imm_ID_EX_o          <= '0;
`ifdef ILLEGAL_INSN_DETECT_EN
                valid_ID_EX_o        <= 1'b1;
                illegal_ID_EX_o      <= 1'b1;
`else
                valid_ID_EX_o        <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: doc/alu_ctrl_gen.md
ALU_CTRL_GEN -- requirements
Module: alu_ctrl_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the immediate and operand datapath width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port instr_ID_i, input, 32 bits: the instruction word in the ID stage.
REQ-005 SHALL have port valid_ID_i, input, 1 bit: instr_ID_i holds a live instruction.
REQ-006 SHALL have port stall_i, input, 1 bit: hold the ID/EX contents.
REQ-007 SHALL have port flush_i, input, 1 bit: replace the ID/EX contents with a bubble.
REQ-008 SHALL have port alu_ctrl_ID_EX_o, output, 4 bits: registered EX ALU opcode.
REQ-009 SHALL have port alu_src_imm_ID_EX_o, output, 1 bit: operand 2 is the immediate, not rs2.
REQ-010 SHALL have port alu_src_pc_ID_EX_o, output, 1 bit: operand 1 is the PC, not rs1.
REQ-011 SHALL have port alu_zero_rs1_ID_EX_o, output, 1 bit: operand 1 is forced to zero (LUI).
REQ-012 SHALL have port imm_ID_EX_o, output, DATA_WIDTH bits: registered, sign-extended immediate.
REQ-013 SHALL have port valid_ID_EX_o, output, 1 bit: the ID/EX slot holds a live instruction.

Function
REQ-014 SHALL encode the ALU opcode as follows: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and.
REQ-015 SHALL decode R-type (opcode 0110011) from funct3 and funct7[5]:
- funct3 000: add when funct7[5]=0, sub when funct7[5]=1.
- funct3 101: srl when funct7[5]=0, sra when funct7[5]=1.
- All other funct3 values map one-to-one to the opcodes of REQ-014.
REQ-016 SHALL decode I-type ALU (opcode 0010011) the same way as R-type, except:
- funct3 000 is always add.
- funct7[5] is consulted only for funct3 101.
- alu_src_imm=1.
REQ-017 SHALL decode LOAD, STORE, JALR, JAL, AUIPC and LUI as add, with operand selects as follows:
- LOAD, STORE, JALR: imm=1.
- JAL, AUIPC: pc=1, imm=1.
- LUI: zero_rs1=1, imm=1.
REQ-018 SHALL decode BRANCH as follows, with imm=0:
- BEQ/BNE: sub.
- BLT/BGE: slt.
- BLTU/BGEU: sltu.
REQ-019 SHALL generate the immediate as I, S, B, U or J format per RV32I, sign-extended to DATA_WIDTH from instr[31].
REQ-020 SHALL, for shift-immediates, place the 5-bit shamt in imm[4:0] with the upper bits zero.
REQ-021 SHALL register all outputs with a latency of one cycle: a decode captured at edge N is visible after edge N.
REQ-022 SHALL, on an edge with flush_i=1, load a bubble regardless of stall_i:
- valid=0, alu_ctrl=0, all selects 0, imm=0.
REQ-023 SHALL, on an edge with stall_i=1 and flush_i=0, hold every output unchanged.
REQ-024 SHALL, otherwise, capture the decode of instr_ID_i with valid_ID_EX_o=valid_ID_i.
REQ-025 SHALL, when valid_ID_i=0, load a bubble exactly as for a flush.
REQ-026 SHALL treat an unrecognised opcode as a bubble (valid=0) unless ILLEGAL_INSN_DETECT_EN is defined.

Reset
REQ-027 SHALL, while rst_n=0, immediately drive all outputs to 0, independent of clk.
REQ-028 SHALL, when reset is asserted mid-stall, discard the held instruction.
REQ-029 SHALL, on the first edge after rst_n rises, behave per REQ-022..REQ-025.

Configuration
REQ-030 SHALL, when ILLEGAL_INSN_DETECT_EN is defined:
- Add output illegal_ID_EX_o, 1 bit, registered with the same stall/flush/reset rules as the other outputs.
- Set illegal_ID_EX_o=1, valid=1, alu_ctrl=0 for an unknown opcode, a bad R-type funct7, or a bad shift-immediate funct7.
REQ-031 SHALL, when ILLEGAL_INSN_DETECT_EN is not defined, omit the illegal_ID_EX_o port, with illegal encodings handled per REQ-026.

Verification
REQ-032 SHALL cover R-type sub: instr 0x40208033 (sub x0,x1,x2), valid=1 -> next cycle alu_ctrl=1, imm_sel=0, valid=1.
REQ-033 SHALL cover srai: instr 0x4050D093 (srai x1,x1,5) -> alu_ctrl=7, imm_sel=1, imm=0x00000005.
REQ-034 SHALL cover BLTU: instr 0xFE20E8E3 (bltu x1,x2,-16) -> alu_ctrl=4, imm=0xFFFFFFF0, imm_sel=0.
REQ-035 SHALL cover LUI: instr 0x123450B7 -> alu_ctrl=0, zero_rs1=1, imm=0x12345000.
REQ-036 SHALL cover stall and flush:
- stall_i=1 for 3 cycles while instr_ID_i changes -> outputs frozen.
- Then stall_i=1 with flush_i=1 -> bubble (valid=0).
REQ-037 SHALL cover asynchronous reset: rst_n pulled low between edges during a held stall -> all outputs 0 before the next edge.
- With the macro defined, additionally: opcode 0x7F -> illegal=1, valid=1.
